// File: rtl/spi_debug_log_reader_pkg.sv
// -----------------------------------------------------------------------------
// spi_debug_log_reader_pkg
// Shared definitions for the SPI debug log reader: reader FSM states, the
// log word map and the record tag values.
// -----------------------------------------------------------------------------
package spi_debug_log_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL,
    ST_CHECK,
    ST_FETCH,
    ST_EMIT
  } state_e;

  // Word 0 holds the writer pointer; records live in words 1..63.
  localparam logic [5:0] LOG_PTR_ADDR = 6'd0;
  localparam logic [5:0] LOG_FIRST    = 6'd1;
  localparam logic [5:0] LOG_LAST     = 6'd63;

  // Record tag byte (bits [7:0] of each record).
  localparam logic [7:0] TAG_MOSI = 8'h00;
  localparam logic [7:0] TAG_MISO = 8'h01;

  // Record pointer advance: 63 wraps to 1, so word 0 is never treated as data.
  function automatic logic [5:0] next_ptr(input logic [5:0] p);
    return (p == LOG_LAST) ? LOG_FIRST : p + 6'd1;
  endfunction

endpackage

// File: rtl/spi_debug_log_reader_if.sv
// -----------------------------------------------------------------------------
// spi_debug_log_reader_if
// Bundles the Avalon-MM read master and the byte-stream output of the reader.
//   master : the reader (drives address/read and the stream data/valid/last)
//   slave  : the log memory and the stream consumer (drive readdata,
//            waitrequest and ready)
// -----------------------------------------------------------------------------
interface spi_debug_log_reader_if;
  logic [5:0]  io_Avalon_address;
  logic        io_Avalon_read;
  logic [63:0] io_Avalon_readdata;
  logic        io_Avalon_waitrequest;
  logic [7:0]  io_Out_data;
  logic        io_Out_valid;
  logic        io_Out_ready;
  logic        io_Out_last;

  modport master (
    output io_Avalon_address, io_Avalon_read,
    input  io_Avalon_readdata, io_Avalon_waitrequest,
    output io_Out_data, io_Out_valid, io_Out_last,
    input  io_Out_ready
  );

  modport slave (
    input  io_Avalon_address, io_Avalon_read,
    output io_Avalon_readdata, io_Avalon_waitrequest,
    input  io_Out_data, io_Out_valid, io_Out_last,
    output io_Out_ready
  );
endinterface

// File: rtl/spi_debug_log_reader_serializer.sv
// -----------------------------------------------------------------------------
// record_serializer
// Holds one 64-bit log record and unloads it as 8 bytes over ready/valid,
// least-significant byte (the tag) first.
//   clock, reset : clock and synchronous active-low reset
//   i_load       : capture i_record and start emitting from byte 0
//   i_record     : record word to serialize
//   i_ready      : consumer ready
//   o_valid      : byte available
//   o_data       : current byte (0 when idle)
//   o_last       : current byte is byte 7
//   o_done       : pulses on the transfer of byte 7
// -----------------------------------------------------------------------------
module record_serializer (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_load,
  input  logic [63:0] i_record,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [7:0]  o_data,
  output logic        o_last,
  output logic        o_done
);

  logic [63:0] r_record;
  logic [2:0]  r_idx;
  logic        r_busy;
  logic        w_xfer;

  assign w_xfer = r_busy && i_ready;

  // NOTE: registers use non-blocking assignments so every flop samples the
  // values that existed before the clock edge, independent of block order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_record <= '0;
      r_idx    <= '0;
      r_busy   <= 1'b0;
    end else if (i_load) begin
      r_record <= i_record;
      r_idx    <= '0;
      r_busy   <= 1'b1;
    end else if (w_xfer) begin
      r_idx <= r_idx + 3'd1;   // 7 rolls over to 0, ready for the next load
      if (r_idx == 3'd7) r_busy <= 1'b0;
    end
  end

  assign o_valid = r_busy;
  assign o_data  = r_busy ? r_record[{r_idx, 3'b000} +: 8] : 8'h00;
  assign o_last  = r_busy && (r_idx == 3'd7);
  assign o_done  = w_xfer && (r_idx == 3'd7);

endmodule

// File: rtl/spi_debug_log_reader.sv
// -----------------------------------------------------------------------------
// spi_debug_log_reader
// Polls the writer pointer of an SPI debug log over Avalon-MM, fetches every
// new 64-bit record and streams it out as 8 bytes with a last marker.
//   clock          : sole clock, rising edge
//   reset          : synchronous active-low reset
//   io_Enable      : permits new polls and fetches (a started record finishes)
//   bus            : Avalon-MM read master + byte stream (master modport)
//   io_RecordCount : records emitted, saturating at 0xFFFF
// -----------------------------------------------------------------------------
module spi_debug_log_reader
  import spi_debug_log_reader_pkg::*;
#(
  parameter int POLL_INTERVAL = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          io_Enable,
  spi_debug_log_reader_if.master        bus,
  output logic [15:0]                   io_RecordCount
);

  localparam logic [15:0] WAIT_TERM = 16'(POLL_INTERVAL - 1);

  state_e      r_state;
  state_e      w_next;
  logic [15:0] r_wait_cnt;
  logic [5:0]  r_rd_ptr;
  logic [5:0]  r_wp;
  logic [15:0] r_record_count;
  logic        w_read;
  logic [5:0]  w_addr;
  logic        w_load;
  logic        w_ser_done;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    w_read = 1'b0;
    w_addr = LOG_PTR_ADDR;
    w_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_wait_cnt == WAIT_TERM && io_Enable) w_next = ST_POLL;
      end
      ST_POLL: begin
        w_read = 1'b1;
        if (!bus.io_Avalon_waitrequest) w_next = ST_CHECK;
      end
      ST_CHECK: begin
        // Decided on the cached writer pointer; EMIT returns here without a re-poll.
        if (r_wp == r_rd_ptr || r_wp == LOG_PTR_ADDR || !io_Enable) w_next = ST_IDLE;
        else                                                        w_next = ST_FETCH;
      end
      ST_FETCH: begin
        w_read = 1'b1;
        w_addr = r_rd_ptr;
        if (!bus.io_Avalon_waitrequest) begin
          w_load = 1'b1;
          w_next = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (w_ser_done) w_next = ST_CHECK;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_wait_cnt     <= '0;
      r_rd_ptr       <= LOG_FIRST;
      r_wp           <= LOG_FIRST;
      r_record_count <= '0;
    end else begin
      r_state <= w_next;
      // The counter restarts on every IDLE entry and parks at terminal count
      // while polling is disabled, so re-enabling polls on the next cycle.
      if (r_state != ST_IDLE)         r_wait_cnt <= '0;
      else if (r_wait_cnt != WAIT_TERM) r_wait_cnt <= r_wait_cnt + 16'd1;
      if (r_state == ST_POLL && !bus.io_Avalon_waitrequest)
        r_wp <= bus.io_Avalon_readdata[5:0];
      if (w_load) r_rd_ptr <= next_ptr(r_rd_ptr);
      if (w_ser_done && r_record_count != 16'hFFFF)
        r_record_count <= r_record_count + 16'd1;
    end
  end

  record_serializer u_serializer (
    .clock    (clock),
    .reset    (reset),
    .i_load   (w_load),
    .i_record (bus.io_Avalon_readdata),
    .i_ready  (bus.io_Out_ready),
    .o_valid  (bus.io_Out_valid),
    .o_data   (bus.io_Out_data),
    .o_last   (bus.io_Out_last),
    .o_done   (w_ser_done)
  );

  assign bus.io_Avalon_read    = w_read;
  assign bus.io_Avalon_address = w_addr;
  assign io_RecordCount        = r_record_count;

endmodule
